// File: rtl/bank_sched_pkg.sv
// Shared types and defaults for the ping-pong bank scheduler.
// The optional drop counter is enabled with `define BANK_SCHED_DROP_CNT_EN.
package bank_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_BUSY,
        S_RESULT
    } scan_state_t;

    localparam int DEFAULT_DW      = 8;
    localparam int DEFAULT_BANK_AW = 8;
    localparam int DROP_CNT_W      = 16;

endpackage

// File: rtl/bank_fill_ctrl.sv
// Fill side of the ping-pong buffer: write pointer, bank-full flag, fill bank select
// and the RAM port A write drive.
module bank_fill_ctrl
    import bank_sched_pkg::*;
#(
    parameter int DW      = DEFAULT_DW,
    parameter int BANK_AW = DEFAULT_BANK_AW,
    localparam int AW     = BANK_AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    input  logic          swap,
    output logic [AW-1:0] ram_addr_a,
    output logic [DW-1:0] ram_data_a,
    output logic          ram_wren_a,
    output logic          bank_full,
    output logic          fill_bank,
    output logic          drop
);

    localparam logic [BANK_AW-1:0] LAST_ADDR = '1;

    logic [BANK_AW-1:0] wptr;
    logic [BANK_AW-1:0] wr_ptr;
    logic               wr_bank;
    logic               accept;

    // A sample arriving on the swap edge goes straight to address 0 of the new fill bank.
    assign wr_bank = swap ? ~fill_bank : fill_bank;
    assign wr_ptr  = swap ? '0 : wptr;
    assign accept  = wr_valid & enable & (~bank_full | swap);
    assign drop    = wr_valid & enable & bank_full & ~swap;

    assign ram_wren_a = rst_n & accept;
    assign ram_addr_a = rst_n ? {wr_bank, wr_ptr} : '0;
    assign ram_data_a = rst_n ? wr_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            bank_full <= 1'b0;
            fill_bank <= 1'b0;
        end else begin
            if (swap) begin
                fill_bank <= ~fill_bank;
            end
            if (accept) begin
                wptr <= wr_ptr + 1'b1;
            end else if (swap) begin
                wptr <= '0;
            end
            if (accept && wr_ptr == LAST_ADDR) begin
                bank_full <= 1'b1;
            end else if (swap) begin
                bank_full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bank_sched.sv
// Ping-pong bank scheduler: fills one bank while an external argmax scans the other.
// Define BANK_SCHED_DROP_CNT_EN to add the saturating drop_count output.
module bank_sched
    import bank_sched_pkg::*;
#(
    parameter int DW      = DEFAULT_DW,
    parameter int BANK_AW = DEFAULT_BANK_AW,
    localparam int AW     = BANK_AW + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               wr_valid,
    input  logic [DW-1:0]      wr_data,
    output logic [AW-1:0]      ram_addr_a,
    output logic [DW-1:0]      ram_data_a,
    output logic               ram_wren_a,
    input  logic [AW-1:0]      am_addr,
    output logic [AW-1:0]      ram_addr_b,
    output logic               am_start,
    input  logic               am_done,
    input  logic [DW-1:0]      am_max,
    input  logic [AW-1:0]      am_index,
    output logic               peak_valid,
    output logic [BANK_AW-1:0] peak_index,
    output logic [DW-1:0]      peak_value,
    output logic               overrun
`ifdef BANK_SCHED_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_count
`endif
);

    scan_state_t state;
    scan_state_t state_next;
    logic        bank_full;
    logic        fill_bank;
    logic        scan_bank;
    logic        swap;
    logic        drop;
    logic        unused;

    assign unused = &{1'b0, am_addr[AW-1], am_index[AW-1]};

    assign scan_bank  = ~fill_bank;
    assign ram_addr_b = {scan_bank, am_addr[BANK_AW-1:0]};
    assign swap       = (state == S_IDLE) & bank_full & enable;

    bank_fill_ctrl #(
        .DW      (DW),
        .BANK_AW (BANK_AW)
    ) u_fill (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .swap       (swap),
        .ram_addr_a (ram_addr_a),
        .ram_data_a (ram_data_a),
        .ram_wren_a (ram_wren_a),
        .bank_full  (bank_full),
        .fill_bank  (fill_bank),
        .drop       (drop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        am_start   = 1'b0;
        peak_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (swap) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                am_start   = 1'b1;
                state_next = S_BUSY;
            end
            S_BUSY: begin
                if (am_done) begin
                    state_next = S_RESULT;
                end
            end
            S_RESULT: begin
                peak_valid = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_index <= '0;
            peak_value <= '0;
            overrun    <= 1'b0;
        end else begin
            if (state == S_BUSY && am_done) begin
                peak_index <= am_index[BANK_AW-1:0];
                peak_value <= am_max;
            end
            if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef BANK_SCHED_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else if (drop && drop_count != {DROP_CNT_W{1'b1}}) begin
            drop_count <= drop_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_bank_sched.sv
// Directed testbench for bank_sched: vector table for port-level behaviour,
// hand-written sequences for the fill/scan/overrun/reset/enable corner cases.
module tb_bank_sched;
    import bank_sched_pkg::*;

    localparam int DW      = 8;
    localparam int BANK_AW = 8;
    localparam int AW      = 9;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               enable = 1'b0;
    logic               wr_valid = 1'b0;
    logic [DW-1:0]      wr_data = '0;
    logic [AW-1:0]      ram_addr_a;
    logic [DW-1:0]      ram_data_a;
    logic               ram_wren_a;
    logic [AW-1:0]      am_addr = '0;
    logic [AW-1:0]      ram_addr_b;
    logic               am_start;
    logic               am_done = 1'b0;
    logic [DW-1:0]      am_max = '0;
    logic [AW-1:0]      am_index = '0;
    logic               peak_valid;
    logic [BANK_AW-1:0] peak_index;
    logic [DW-1:0]      peak_value;
    logic               overrun;
`ifdef BANK_SCHED_DROP_CNT_EN
    logic [15:0]        drop_count;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bank_sched #(
        .DW      (DW),
        .BANK_AW (BANK_AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .ram_addr_a (ram_addr_a),
        .ram_data_a (ram_data_a),
        .ram_wren_a (ram_wren_a),
        .am_addr    (am_addr),
        .ram_addr_b (ram_addr_b),
        .am_start   (am_start),
        .am_done    (am_done),
        .am_max     (am_max),
        .am_index   (am_index),
        .peak_valid (peak_valid),
        .peak_index (peak_index),
        .peak_value (peak_value),
        .overrun    (overrun)
`ifdef BANK_SCHED_DROP_CNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    typedef struct {
        logic          rst;
        logic          en;
        logic          wv;
        logic [DW-1:0] wd;
        logic [AW-1:0] aa;
        logic          done;
        logic          exp_wren;
        logic [AW-1:0] exp_addr_a;
        logic [DW-1:0] exp_data_a;
        logic [AW-1:0] exp_addr_b;
        logic          exp_start;
        logic          exp_peak;
    } vec_t;

    vec_t vt[7];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Advance one cycle: drive inputs just after the rising edge, return at the falling edge.
    task automatic applyStimulus(input logic en, input logic wv, input logic [DW-1:0] wd,
                                 input logic done, input logic [DW-1:0] mx, input logic [AW-1:0] idx);
        @(posedge clk);
        #1;
        enable   = en;
        wr_valid = wv;
        wr_data  = wd;
        am_done  = done;
        am_max   = mx;
        am_index = idx;
        @(negedge clk);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        enable   = 1'b0;
        wr_valid = 1'b0;
        am_done  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic          wv;
        logic          done;
        logic [DW-1:0] wd;
        logic [DW-1:0] mx;
        logic [AW-1:0] idx;

        vt[0] = '{1'b0, 1'b1, 1'b1, 8'h5A, 9'h0FF, 1'b0, 1'b0, 9'h000, 8'h00, 9'h1FF, 1'b0, 1'b0};
        vt[1] = '{1'b1, 1'b1, 1'b1, 8'h5A, 9'h0FF, 1'b0, 1'b1, 9'h000, 8'h5A, 9'h1FF, 1'b0, 1'b0};
        vt[2] = '{1'b1, 1'b0, 1'b1, 8'h33, 9'h155, 1'b0, 1'b0, 9'h001, 8'h33, 9'h155, 1'b0, 1'b0};
        vt[3] = '{1'b1, 1'b1, 1'b0, 8'h44, 9'h0AA, 1'b0, 1'b0, 9'h001, 8'h44, 9'h1AA, 1'b0, 1'b0};
        vt[4] = '{1'b1, 1'b1, 1'b1, 8'h77, 9'h100, 1'b0, 1'b1, 9'h001, 8'h77, 9'h100, 1'b0, 1'b0};
        vt[5] = '{1'b1, 1'b1, 1'b0, 8'h00, 9'h000, 1'b1, 1'b0, 9'h002, 8'h00, 9'h100, 1'b0, 1'b0};
        vt[6] = '{1'b1, 1'b1, 1'b0, 8'h00, 9'h000, 1'b0, 1'b0, 9'h002, 8'h00, 9'h100, 1'b0, 1'b0};

        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            rst_n    = vt[i].rst;
            enable   = vt[i].en;
            wr_valid = vt[i].wv;
            wr_data  = vt[i].wd;
            am_addr  = vt[i].aa;
            am_done  = vt[i].done;
            @(negedge clk);
            checkOutput($sformatf("vec%0d wren", i), 32'(ram_wren_a), 32'(vt[i].exp_wren));
            checkOutput($sformatf("vec%0d addr_a", i), 32'(ram_addr_a), 32'(vt[i].exp_addr_a));
            checkOutput($sformatf("vec%0d data_a", i), 32'(ram_data_a), 32'(vt[i].exp_data_a));
            checkOutput($sformatf("vec%0d addr_b", i), 32'(ram_addr_b), 32'(vt[i].exp_addr_b));
            checkOutput($sformatf("vec%0d am_start", i), 32'(am_start), 32'(vt[i].exp_start));
            checkOutput($sformatf("vec%0d peak_valid", i), 32'(peak_valid), 32'(vt[i].exp_peak));
            if (i == 0) begin
                checkOutput("reset overrun", 32'(overrun), 32'h0);
                checkOutput("reset peak_index", 32'(peak_index), 32'h0);
                checkOutput("reset peak_value", 32'(peak_value), 32'h0);
            end
        end

        // Two full banks, an early scan result, then an overrun during a long scan.
        doReset();
        am_addr = 9'h033;
        for (int c = 0; c < 784; c++) begin
            wv   = (c < 778) || (c == 782);
            wd   = (c == 782) ? 8'h55 : ((c == 256) ? 8'hAA : 8'(c));
            done = (c == 260) || (c == 780);
            mx   = (c < 700) ? 8'hC3 : 8'h9D;
            idx  = (c < 700) ? 9'h17A : 9'h0E5;
            applyStimulus(1'b1, wv, wd, done, mx, idx);
            if (c < 256) begin
                checkOutput($sformatf("fill0 wren c%0d", c), 32'(ram_wren_a), 32'h1);
                checkOutput($sformatf("fill0 addr c%0d", c), 32'(ram_addr_a), 32'(c));
                checkOutput($sformatf("fill0 data c%0d", c), 32'(ram_data_a), 32'(c & 255));
                checkOutput($sformatf("fill0 start c%0d", c), 32'(am_start), 32'h0);
            end else if (c < 512) begin
                checkOutput($sformatf("fill1 wren c%0d", c), 32'(ram_wren_a), 32'h1);
                checkOutput($sformatf("fill1 addr c%0d", c), 32'(ram_addr_a), 32'(c));
            end else if (c < 768) begin
                checkOutput($sformatf("fill2 wren c%0d", c), 32'(ram_wren_a), 32'h1);
                checkOutput($sformatf("fill2 addr c%0d", c), 32'(ram_addr_a), 32'(c - 512));
            end else if (c < 778) begin
                checkOutput($sformatf("drop wren c%0d", c), 32'(ram_wren_a), 32'h0);
            end
            case (c)
                256: begin
                    checkOutput("swap1 data", 32'(ram_data_a), 32'hAA);
                    checkOutput("swap1 start", 32'(am_start), 32'h0);
                end
                257: begin
                    checkOutput("scan1 start", 32'(am_start), 32'h1);
                    checkOutput("scan1 addr_b", 32'(ram_addr_b), 32'h033);
                end
                258: checkOutput("scan1 start pulse", 32'(am_start), 32'h0);
                260: checkOutput("scan1 peak early", 32'(peak_valid), 32'h0);
                261: begin
                    checkOutput("scan1 peak_valid", 32'(peak_valid), 32'h1);
                    checkOutput("scan1 peak_index", 32'(peak_index), 32'h7A);
                    checkOutput("scan1 peak_value", 32'(peak_value), 32'hC3);
                end
                262: begin
                    checkOutput("scan1 peak pulse", 32'(peak_valid), 32'h0);
                    checkOutput("scan1 index held", 32'(peak_index), 32'h7A);
                end
                513: begin
                    checkOutput("scan2 start", 32'(am_start), 32'h1);
                    checkOutput("scan2 addr_b", 32'(ram_addr_b), 32'h133);
                end
                768: checkOutput("overrun before drop", 32'(overrun), 32'h0);
                769: checkOutput("overrun set", 32'(overrun), 32'h1);
                779: begin
                    checkOutput("overrun sticky", 32'(overrun), 32'h1);
`ifdef BANK_SCHED_DROP_CNT_EN
                    checkOutput("drop_count", 32'(drop_count), 32'd10);
`endif
                end
                781: begin
                    checkOutput("scan2 peak_valid", 32'(peak_valid), 32'h1);
                    checkOutput("scan2 peak_index", 32'(peak_index), 32'hE5);
                    checkOutput("scan2 peak_value", 32'(peak_value), 32'h9D);
                    checkOutput("scan2 no swap yet", 32'(am_start), 32'h0);
                end
                782: begin
                    checkOutput("swap3 wren", 32'(ram_wren_a), 32'h1);
                    checkOutput("swap3 addr", 32'(ram_addr_a), 32'h100);
                    checkOutput("swap3 data", 32'(ram_data_a), 32'h55);
                    checkOutput("swap3 start", 32'(am_start), 32'h0);
                end
                783: checkOutput("scan3 start", 32'(am_start), 32'h1);
                default: ;
            endcase
        end

        // Reset while the third scan is busy; a late am_done must be ignored.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 9'h000);
        @(posedge clk);
        #1;
        rst_n    = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 8'h66;
        #1;
        checkOutput("rst wren", 32'(ram_wren_a), 32'h0);
        checkOutput("rst addr_a", 32'(ram_addr_a), 32'h0);
        checkOutput("rst data_a", 32'(ram_data_a), 32'h0);
        checkOutput("rst am_start", 32'(am_start), 32'h0);
        checkOutput("rst peak_valid", 32'(peak_valid), 32'h0);
        checkOutput("rst overrun", 32'(overrun), 32'h0);
        checkOutput("rst peak_index", 32'(peak_index), 32'h0);
        checkOutput("rst peak_value", 32'(peak_value), 32'h0);
        checkOutput("rst addr_b", 32'(ram_addr_b), 32'h133);
`ifdef BANK_SCHED_DROP_CNT_EN
        checkOutput("rst drop_count", 32'(drop_count), 32'h0);
`endif
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        wr_valid = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 8'hEE, 9'h011);
        checkOutput("late done peak", 32'(peak_valid), 32'h0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 9'h000);
        checkOutput("late done peak next", 32'(peak_valid), 32'h0);
        checkOutput("late done start", 32'(am_start), 32'h0);
        checkOutput("late done index", 32'(peak_index), 32'h0);

        // Fill a bank, hold enable low, then release it; disable again mid-scan.
        for (int c = 0; c < 256; c++) begin
            applyStimulus(1'b1, 1'b1, 8'(c), 1'b0, 8'h00, 9'h000);
        end
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 9'h000);
            checkOutput($sformatf("enable low start %0d", c), 32'(am_start), 32'h0);
        end
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 9'h000);
        checkOutput("enable swap cycle start", 32'(am_start), 32'h0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 9'h000);
        checkOutput("enable raised start", 32'(am_start), 32'h1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 8'h42, 9'h1FF);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 9'h000);
        checkOutput("disabled scan peak_valid", 32'(peak_valid), 32'h1);
        checkOutput("disabled scan peak_index", 32'(peak_index), 32'hFF);
        checkOutput("disabled scan peak_value", 32'(peak_value), 32'h42);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
